// File: rtl/irq_pkg.sv
// Shared widths and types for the irq_encoder request arbiter.
package irq_pkg;

  localparam int IRQ_N = 8;
  localparam int IRQ_W = 3;

  typedef logic [IRQ_N-1:0] irq_vec_t;
  typedef logic [IRQ_W-1:0] irq_code_t;

  function automatic irq_vec_t irq_onehot(input irq_code_t idx);
    irq_vec_t v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_enc4.sv
// Combinational 4-to-2 priority encoder; the highest set input index wins.
module prio_enc4 (
  input  logic [3:0] in,
  output logic [1:0] code,
  output logic       any
);

  always_comb begin
    code = 2'd0;
    any  = 1'b1;
    casez (in)
      4'b1???: code = 2'd3;
      4'b01??: code = 2'd2;
      4'b001?: code = 2'd1;
      4'b0001: code = 2'd0;
      default: any  = 1'b0;
    endcase
  end

endmodule

// File: rtl/irq_encoder.sv
// Registered 8-to-3 priority encoder with sticky pending bits and valid/ack handshake.
// Optional IRQ_ENCODER_MASK_EN adds a mask input that excludes bits from arbitration.
module irq_encoder
  import irq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       ack,
`ifdef IRQ_ENCODER_MASK_EN
  input  logic [7:0] mask,
`endif
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pending
);

  irq_vec_t  pending_q, pending_d;
  irq_code_t code_q, code_d;
  logic      valid_q, valid_d;

  irq_vec_t  clear;
  irq_vec_t  eligible;
  logic [1:0] hi_code, lo_code;
  logic       hi_any, lo_any;
  irq_code_t  winner;
  logic       winner_any;

  // Set wins over clear: req is ORed in after the served bit is removed.
  always_comb begin
    clear     = (valid_q && ack) ? irq_onehot(code_q) : '0;
    pending_d = (pending_q & ~clear) | req;
`ifdef IRQ_ENCODER_MASK_EN
    eligible  = pending_d & ~mask;
`else
    eligible  = pending_d;
`endif
  end

  prio_enc4 u_enc_hi (
    .in   (eligible[7:4]),
    .code (hi_code),
    .any  (hi_any)
  );

  prio_enc4 u_enc_lo (
    .in   (eligible[3:0]),
    .code (lo_code),
    .any  (lo_any)
  );

  assign winner     = hi_any ? {1'b1, hi_code} : {1'b0, lo_code};
  assign winner_any = hi_any | lo_any;

  // The presented code is frozen until acknowledged, even if a higher index arrives.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    if (!valid_q || ack) begin
      valid_d = winner_any;
      code_d  = winner_any ? winner : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_irq_encoder.sv
// Self-checking bench for irq_encoder: directed test-plan scenarios plus random traffic vs a model.
module tb_irq_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       ack;
  logic [7:0] mask;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;

  int checks;
  int errors;

  // reference model state
  logic [7:0] m_pending;
  logic       m_valid;
  logic [2:0] m_code;

  irq_encoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .ack     (ack),
`ifdef IRQ_ENCODER_MASK_EN
    .mask    (mask),
`endif
    .code    (code),
    .valid   (valid),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: one clock edge using the spec's set/clear/arbitrate rules.
  task automatic model_step();
    logic [7:0] nxt;
    int         win;
    nxt = m_pending;
    if (m_valid && ack) nxt[m_code] = 1'b0;
    nxt = nxt | req;
    win = -1;
    for (int i = 0; i < 8; i++) begin
`ifdef IRQ_ENCODER_MASK_EN
      if (nxt[i] && !mask[i]) win = i;
`else
      if (nxt[i]) win = i;
`endif
    end
    if (!m_valid || ack) begin
      m_valid = (win >= 0);
      m_code  = (win >= 0) ? 3'(win) : 3'd0;
    end
    m_pending = nxt;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    ack   = 1'b0;
    mask  = '0;
    m_pending = '0;
    m_valid   = 1'b0;
    m_code    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({valid, code, pending} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got v=%0b c=%0d p=%h, expected v=0 c=0 p=00", valid, code, pending);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({valid, code, pending} !== 12'h000) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got v=%0b c=%0d p=%h, expected v=0 c=0 p=00", i, valid, code, pending);
      end
    end
  endtask

  // Each row: req, ack, expected valid, code, pending after the edge.
  task automatic run_table(input string name, input logic [7:0] t_req[], input logic t_ack[],
                           input logic t_v[], input logic [2:0] t_c[], input logic [7:0] t_p[]);
    for (int i = 0; i < t_req.size(); i++) begin
      req = t_req[i];
      ack = t_ack[i];
      tick();
      checks++;
      if ({valid, code, pending} !== {t_v[i], t_c[i], t_p[i]}) begin
        errors++;
        $display("FAIL %s[%0d]: got v=%0b c=%0d p=%h, expected v=%0b c=%0d p=%h",
                 name, i, valid, code, pending, t_v[i], t_c[i], t_p[i]);
      end
    end
    req = '0;
    ack = 1'b0;
  endtask

  task automatic test_single_request();
    do_reset();
    run_table("single_req",
      '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
      '{3'd3, 3'd3, 3'd3, 3'd3, 3'd0},
      '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00});
  endtask

  task automatic test_priority_hold();
    do_reset();
    run_table("prio_hold",
      '{8'h05, 8'h80, 8'h00, 8'h00, 8'h00},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
      '{3'd2, 3'd2, 3'd7, 3'd0, 3'd0},
      '{8'h05, 8'h85, 8'h81, 8'h01, 8'h00});
  endtask

  task automatic test_set_and_clear();
    do_reset();
    run_table("set_clear",
      '{8'h10, 8'h10, 8'h00, 8'h00},
      '{1'b0, 1'b1, 1'b1, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b0},
      '{3'd4, 3'd4, 3'd0, 3'd0},
      '{8'h10, 8'h10, 8'h00, 8'h00});
  endtask

  task automatic test_async_reset();
    do_reset();
    run_table("pre_async",
      '{8'hFF}, '{1'b0}, '{1'b1}, '{3'd7}, '{8'hFF});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, code, pending} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got v=%0b c=%0d p=%h, expected v=0 c=0 p=00", valid, code, pending);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_table("post_async",
      '{8'h00, 8'h00}, '{1'b0, 1'b1}, '{1'b0, 1'b0}, '{3'd0, 3'd0}, '{8'h00, 8'h00});
  endtask

`ifdef IRQ_ENCODER_MASK_EN
  task automatic test_mask();
    do_reset();
    mask = 8'hF0;
    run_table("mask_on",
      '{8'h81, 8'h00}, '{1'b0, 1'b1}, '{1'b1, 1'b0}, '{3'd0, 3'd0}, '{8'h81, 8'h80});
    mask = 8'h00;
    run_table("mask_off",
      '{8'h00}, '{1'b0}, '{1'b1}, '{3'd7}, '{8'h80});
    mask = 8'h00;
  endtask
`endif

  task automatic test_random();
    logic [2:0] held_code;
    logic       held;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      req  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      ack  = ($urandom_range(0, 2) != 0);
      mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      held      = valid && !ack;
      held_code = code;
      tick();
      checks++;
      if ({valid, code, pending} !== {m_valid, m_code, m_pending}) begin
        errors++;
        $display("FAIL random[%0d]: got v=%0b c=%0d p=%h, expected v=%0b c=%0d p=%h",
                 i, valid, code, pending, m_valid, m_code, m_pending);
      end
      if (held) begin
        checks++;
        if (!valid || code !== held_code) begin
          errors++;
          $display("FAIL hold[%0d]: got v=%0b c=%0d, expected v=1 c=%0d", i, valid, code, held_code);
        end
      end
    end
    req  = '0;
    ack  = 1'b0;
    mask = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = '0;
    ack    = 1'b0;
    mask   = '0;
    test_reset();
    test_single_request();
    test_priority_hold();
    test_set_and_clear();
    test_async_reset();
`ifdef IRQ_ENCODER_MASK_EN
    test_mask();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_encoder.md
# irq_encoder

Registered 8-to-3 priority encoder with a valid/ack handshake. It is the encoding counterpart of the 3-to-8 decoder used in the Lista5 logic designs. Eight request lines are latched into a sticky pending register. The highest-numbered pending request is presented as a 3-bit code and held stable until the consumer acknowledges it. It sits between a bank of request sources and a single consumer that services one index at a time.

## Interface
- N, 8, number of request lines; only 8 is supported.
- W, 3, code width, equal to $clog2(N).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N  request pulses or levels; bit i high at an edge sets pending[i].
- ack  in  1  consumer accepts the current code; meaningful only while valid=1.
- code  out  W  index of the request being presented; registered.
- valid  out  1  code is valid; registered.
- pending  out  N  the pending register, for debug and visibility.
- mask  in  N  present only with IRQ_ENCODER_MASK_EN; 1 = bit i is not eligible for arbitration.

## Operation
- Reset (rst_n=0, asynchronous): pending=8'h00, valid=0, code=3'd0. Requests in flight are discarded.
- clear = one-hot(code) when valid&&ack, otherwise 0.
- pending_nxt = (pending & ~clear) | req.
  - If a bit is set and cleared at the same edge, set wins: the new request stays pending.
- eligible = pending_nxt, ANDed with ~mask when the mask feature is compiled in.
- Arbitration is fixed priority: the highest set index of eligible wins. Index 7 beats index 0.
- Output register update:
  - When valid=0 or ack=1: valid <= |eligible and code <= winner index.
  - When eligible is empty: code <= 0.
  - When valid=1 and ack=0: valid and code hold, even if a higher-priority request arrives. The pending register still latches that request.
- A request already pending that is asserted again does nothing extra. There is no counting and no overflow.
- ack while valid=0 is ignored and clears nothing.

## Timing
- Request latency:
  - req[i] high at edge k → pending[i]=1 and, if i wins, valid=1 / code=i after edge k.
  - Latency is 1 cycle from the sampled request to valid.
- Ack:
  - ack=1 at edge k clears the served bit at edge k.
  - At the same edge the output reloads with the next winner, or valid drops if nothing else is eligible.
  - Back-to-back service is therefore one code per cycle, with no idle cycle between codes.
- Hold: code stays stable while valid=1 and ack=0. This is a hard requirement for the verifier.
- Reset asserted mid-handshake forces the reset values immediately, without waiting for a clock edge. The first request after rst_n deasserts is sampled at the first edge.

## Configuration
- IRQ_ENCODER_MASK_EN defined:
  - The mask port exists.
  - Masked bits still latch into pending and appear on the pending output.
  - Masked bits never win arbitration.
  - Unmasking a pending bit makes it eligible at the next output update.
  - Masking the bit currently presented does not withdraw it while valid=1 and ack=0.
- Not defined:
  - No mask port.
  - All pending bits are eligible.

## Structure
- Shared package irq_pkg contains:
  - IRQ_N=8 and IRQ_W=3;
  - typedef irq_vec_t (logic [IRQ_N-1:0]);
  - typedef irq_code_t (logic [IRQ_W-1:0]).
- Sub-module prio_enc4: combinational 4-to-2 priority encoder with outputs code[1:0] and any.
  - irq_encoder instantiates two of them, one on bits [7:4] and one on [3:0].
  - The upper instance wins when its any=1, giving code = {upper.any, selected 2-bit code}.
  - This mirrors the two-decoder composition of the 3-to-8 decoder.

## Test plan
- Reset then idle: rst_n low, then high, req=0 for 5 cycles → valid=0, code=0, pending=00 throughout.
- Single request: req=8'h08 for one cycle at edge k → after edge k valid=1, code=3, pending=08. Hold ack=0 for 3 cycles → unchanged. ack=1 → valid=0, pending=00.
- Priority and hold: req=8'h05 at edge k → code=2. Then req=8'h80 with ack=0 → code stays 2 and pending=85. Then ack=1 → code=7. Then ack=1 → code=0. Then ack=1 → valid=0.
- Simultaneous set and clear: code=4 valid, ack=1 and req=8'h10 at the same edge → pending[4] stays 1, valid=1, code=4.
- Async reset mid-operation: pending=8'hFF, valid=1, code=7. Drop rst_n between edges → outputs go to 0 before the next edge. Release rst_n with req=0 → valid stays 0.
- Mask (IRQ_ENCODER_MASK_EN): mask=8'hF0, req=8'h81 → code=0 and pending=81. Ack it, then set mask=8'h00 → code=7 at the next edge.
